// File: rtl/unaverage.sv
// ============================================================================
// unaverage
// ----------------------------------------------------------------------------
// Purpose:
//    Inverse of the 3-tap divide-and-sum averager. The averager produces
//    y[n] = (x[n] + x[n-1] + x[n-2]) / 3. This block takes that stream and
//    rebuilds the source samples with the recurrence
//       x[n] = 3*(y[n] - y[n-1]) + x[n-3]
//    starting from an all-zero history. It also reports whether the
//    reconstruction has reached steady state (locked) and whether the last
//    emitted sample fell outside 0..255 before it was limited (range_flag).
//
// Ports:
//    clk           in   1   sole clock, all logic on the rising edge
//    reset         in   1   synchronous, active-high, clears all state
//    avg_in        in   8   averaged sample y[n], unsigned
//    in_valid      in   1   avg_in carries a new sample this cycle
//    resync        in   1   synchronous clear of history, FSM and count;
//                           a sample arriving in the same cycle is treated
//                           as n=0 against the cleared history
//    val_out       out  8   reconstructed sample x[n]
//    out_valid     out  1   one-cycle strobe, val_out was just updated
//    locked        out  1   high once three samples have been accepted
//    range_flag    out  1   last emitted sample was out of range pre-limit
//    sample_count  out 16   samples accepted since reset/resync, saturating
//
// Configuration:
//    UNAVERAGE_SAT_EN  defined   -> out-of-range results clamp to 0 / 255
//                      undefined -> out-of-range results wrap (low 8 bits)
//    In both builds the emitted (limited) value is what enters the x history,
//    so the reconstruction stays consistent with what downstream logic saw.
//
// Exactness:
//    The result is bit-exact when every source sample is a multiple of 3.
//    Otherwise the truncation residue of the forward divide propagates along
//    each mod-3 index chain; that is expected behaviour, not a fault.
// ============================================================================
module unaverage (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  avg_in,
   input  logic        in_valid,
   input  logic        resync,
   output logic [7:0]  val_out,
   output logic        out_valid,
   output logic        locked,
   output logic        range_flag,
   output logic [15:0] sample_count
);

   // Lock-state machine: EMPTY until the first sample, FILL while the first
   // two samples are being rebuilt, RUN from the third sample on.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t state_q, state_d;

   // History registers. x1..x3 hold the emitted (post-limit) samples.
   logic [7:0]  y_prev_q, y_prev_d;
   logic [7:0]  x1_q, x1_d;
   logic [7:0]  x2_q, x2_d;
   logic [7:0]  x3_q, x3_d;

   // Registered outputs.
   logic [7:0]  val_q, val_d;
   logic        out_valid_q, out_valid_d;
   logic        range_q, range_d;
   logic [15:0] count_q, count_d;

   // Datapath intermediates.
   logic [7:0]         hist_y;
   logic [7:0]         hist_x3;
   logic signed [10:0] delta_y;
   logic signed [10:0] three_delta_y;
   logic signed [10:0] raw_sum;
   logic               is_negative;
   logic               is_over;
   logic               out_of_range;
   logic [7:0]         limited;

   // ------------------------------------------------------------------------
   // Reconstruction datapath.
   // A resync in the same cycle as a sample means that sample must see the
   // cleared history, so the history operands are forced to zero here rather
   // than waiting for the registers to clear. Operands are zero-extended to
   // 11 bits before the subtraction so the difference can never overflow:
   // delta in -255..255, 3*delta in -765..765, sum in -765..1020.
   // ------------------------------------------------------------------------
   always_comb begin
      hist_y        = resync ? 8'd0 : y_prev_q;
      hist_x3       = resync ? 8'd0 : x3_q;
      delta_y       = $signed({3'b000, avg_in}) - $signed({3'b000, hist_y});
      three_delta_y = delta_y + (delta_y <<< 1);
      raw_sum       = three_delta_y + $signed({3'b000, hist_x3});

      // Sign bit marks a negative result; any of bits 9:8 set on a positive
      // result means it exceeds 255.
      is_negative  = raw_sum[10];
      is_over      = ~raw_sum[10] & (|raw_sum[9:8]);
      out_of_range = is_negative | is_over;

`ifdef UNAVERAGE_SAT_EN
      // Clamp build: pin to the nearest representable value.
      if (is_negative) begin
         limited = 8'd0;
      end else if (is_over) begin
         limited = 8'd255;
      end else begin
         limited = raw_sum[7:0];
      end
`else
      // Wrap build: keep the low byte and let range_flag report the fault.
      limited = raw_sum[7:0];
`endif
   end

   // ------------------------------------------------------------------------
   // Next-state for history, outputs and sample counter.
   // Everything holds by default; out_valid is a strobe so it defaults low.
   // resync clears history first, then an accepted sample (if any) shifts
   // into that cleared history so it behaves as sample n=0.
   // ------------------------------------------------------------------------
   always_comb begin
      y_prev_d    = y_prev_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      x3_d        = x3_q;
      val_d       = val_q;
      out_valid_d = 1'b0;
      range_d     = range_q;
      count_d     = count_q;

      if (resync) begin
         y_prev_d = 8'd0;
         x1_d     = 8'd0;
         x2_d     = 8'd0;
         x3_d     = 8'd0;
         count_d  = 16'd0;
      end

      if (in_valid) begin
         y_prev_d    = avg_in;
         x3_d        = resync ? 8'd0 : x2_q;
         x2_d        = resync ? 8'd0 : x1_q;
         x1_d        = limited;
         val_d       = limited;
         out_valid_d = 1'b1;
         range_d     = out_of_range;

         if (resync) begin
            count_d = 16'd1;
         end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Lock FSM next-state.
   // While in FILL the sample counter is exactly 1 or 2, so seeing 2 on an
   // accepted sample means this is the third one and the machine locks on
   // the same edge that emits it. resync overrides the normal transitions.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_valid) begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (in_valid && (count_q == 16'd2)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase

      if (resync) begin
         state_d = in_valid ? ST_FILL : ST_EMPTY;
      end
   end

   // ------------------------------------------------------------------------
   // State register. reset wins over resync and in_valid, so a sample that
   // arrives during reset is dropped and every output returns to zero.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         y_prev_q    <= 8'd0;
         x1_q        <= 8'd0;
         x2_q        <= 8'd0;
         x3_q        <= 8'd0;
         val_q       <= 8'd0;
         out_valid_q <= 1'b0;
         range_q     <= 1'b0;
         count_q     <= 16'd0;
      end else begin
         state_q     <= state_d;
         y_prev_q    <= y_prev_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         x3_q        <= x3_d;
         val_q       <= val_d;
         out_valid_q <= out_valid_d;
         range_q     <= range_d;
         count_q     <= count_d;
      end
   end

   // Output mapping. locked is a pure decode of the registered state.
   assign val_out      = val_q;
   assign out_valid    = out_valid_q;
   assign range_flag   = range_q;
   assign sample_count = count_q;
   assign locked       = (state_q == ST_RUN);

endmodule
